contador_maquina: RTL

Button-driven 5-bit count state machine that generates the binary value shown on the two-digit seven-segment display. Its `Q` output connects directly to the 5-bit input `A` of `decodificador_display`. Three push buttons control it: start/resume, pause and clear. A direction level selects counting up or down. It counts at a prescaled rate and stops in an end state at the terminal value.

---
 rtl/contador_maquina_if.sv | 21 ++
 rtl/contador_maquina.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/contador_maquina_if.sv
// Button/direction inputs and count/state outputs of the count state machine.
// The master side is the panel (buttons, dir); the slave side is the counter.
interface contador_maquina_if;
    logic       btn_inicia;
    logic       btn_para;
    logic       btn_zera;
    logic       dir;
    logic [4:0] Q;
    logic [1:0] estado;
    logic       fim;

    modport master (
        output btn_inicia, btn_para, btn_zera, dir,
        input  Q, estado, fim
    );

    modport slave (
        input  btn_inicia, btn_para, btn_zera, dir,
        output Q, estado, fim
    );
endinterface

// File: rtl/contador_maquina.sv
// Button-driven 5-bit up/down counter with prescaler, pause, clear and end state.
// Q feeds the A input of decodificador_display directly.
module contador_maquina #(
    parameter int DIV = 50_000_000,
    parameter int MAX = 31
) (
    input  logic               clk,
    input  logic               rst,
    contador_maquina_if.slave  bus
);
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [4:0]       Q_MAX    = 5'(MAX);

    localparam logic [1:0] PARADO   = 2'b00;
    localparam logic [1:0] CONTANDO = 2'b01;
    localparam logic [1:0] PAUSADO  = 2'b10;
    localparam logic [1:0] FIM      = 2'b11;

    // Bit order: 0 inicia, 1 para, 2 zera, 3 dir.
    logic [3:0] raw;
    logic [3:0] sync;
    logic [2:0] pulse;

    assign raw = {bus.dir, bus.btn_zera, bus.btn_para, bus.btn_inicia};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync[gi] = s2_reg;
        end

        for (gi = 0; gi < 3; gi++) begin : g_edge
            logic prev_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) prev_reg <= 1'b0;
                else     prev_reg <= sync[gi];
            end
            assign pulse[gi] = sync[gi] & ~prev_reg;
        end
    endgenerate

    logic p_inicia;
    logic p_para;
    logic p_zera;
    logic dir_sync;

    assign p_inicia = pulse[0];
    assign p_para   = pulse[1];
    assign p_zera   = pulse[2];
    assign dir_sync = sync[3];

    logic [1:0]       estado_reg, estado_next;
    logic [4:0]       q_reg, q_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic             dir_lat_reg, dir_lat_next;
    logic             fim_reg;

    logic [4:0] q_load;
    logic [4:0] q_step;
    logic [4:0] q_term;

    assign q_load = dir_sync    ? Q_MAX       : 5'd0;
    assign q_step = dir_lat_reg ? q_reg - 5'd1 : q_reg + 5'd1;
    assign q_term = dir_lat_reg ? 5'd0         : Q_MAX;

    always_comb begin
        estado_next  = estado_reg;
        q_next       = q_reg;
        pre_next     = pre_reg;
        dir_lat_next = dir_lat_reg;
        case (estado_reg)
            PARADO: begin
                if (p_inicia) begin
                    estado_next  = CONTANDO;
                    q_next       = q_load;
                    pre_next     = '0;
                    dir_lat_next = dir_sync;
                end
            end
            CONTANDO: begin
                if (p_zera) begin
                    estado_next = PARADO;
                    q_next      = 5'd0;
                    pre_next    = '0;
                end else if (p_para) begin
                    // Pause beats a coinciding tick; pre stays at its last value so
                    // the pending step happens on the first cycle after resume.
                    estado_next = PAUSADO;
                end else if (pre_reg == PRE_LAST) begin
                    pre_next = '0;
                    q_next   = q_step;
                    if (q_step == q_term) estado_next = FIM;
                end else begin
                    pre_next = pre_reg + 1'b1;
                end
            end
            PAUSADO: begin
                if (p_zera) begin
                    estado_next = PARADO;
                    q_next      = 5'd0;
                    pre_next    = '0;
                end else if (p_inicia) begin
                    estado_next = CONTANDO;
                end
            end
            default: begin
                if (p_zera) begin
                    estado_next = PARADO;
                    q_next      = 5'd0;
                    pre_next    = '0;
                end else if (p_inicia) begin
                    estado_next  = CONTANDO;
                    q_next       = q_load;
                    pre_next     = '0;
                    dir_lat_next = dir_sync;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg  <= PARADO;
            q_reg       <= 5'd0;
            pre_reg     <= '0;
            dir_lat_reg <= 1'b0;
            fim_reg     <= 1'b0;
        end else begin
            estado_reg  <= estado_next;
            q_reg       <= q_next;
            pre_reg     <= pre_next;
            dir_lat_reg <= dir_lat_next;
            fim_reg     <= (estado_next == FIM);
        end
    end

    assign bus.Q      = q_reg;
    assign bus.estado = estado_reg;
    assign bus.fim    = fim_reg;
endmodule
